// File: rtl/fpna_pkg.sv
// Shared definitions for the FPNA configuration path: sync word, default
// array geometry and the loader state encoding.
package fpna_pkg;

  localparam logic [7:0] SYNC_WORD = 8'hA5;

  localparam int CELL_COUNT_DEF = 10;
  localparam int CELL_CFG_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    SHIFT = 2'd2
  } cfg_state_t;

  // Next sync-window value after shifting one serial bit in at the LSB.
  function automatic logic [7:0] sync_shift(input logic [7:0] cur, input logic bit_in);
    return {cur[6:0], bit_in};
  endfunction

endpackage

// File: rtl/fpna_sync_detect.sv
// 8-bit sliding window over the serial stream with a sync-word comparator.
// The match output looks at the window *including* the bit currently on
// bit_in, so the loader can leave SYNC on the very edge that completes 0xA5.
module fpna_sync_detect
  import fpna_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  input  logic bit_in,
  output logic match
);

  logic [7:0] sync_reg;
  logic [7:0] nxt;

  assign nxt   = sync_shift(sync_reg, bit_in);
  assign match = enable && (nxt == SYNC_WORD);

  // Window register: clear wins over shift so a zero-filled start is guaranteed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_reg <= '0;
    end else if (clear) begin
      sync_reg <= '0;
    end else if (enable) begin
      sync_reg <= nxt;
    end
  end

endmodule

// File: rtl/fpna_config_loader.sv
// Serial configuration loader: finds the sync word, shifts the payload into a
// shadow register and commits it to cfg_word only when the payload length is
// exact. The shadow MSB feeds bs_out so chips can be daisy-chained.
//
// Handshake: there is no valid/ready pair. config_en qualifies bs_in on every
// rising edge; the first low sample after a frame is the end-of-frame edge,
// and cfg_load is a one-cycle pulse in the cycle cfg_word changes.
module fpna_config_loader
  import fpna_pkg::*;
#(
  parameter int CELL_COUNT = CELL_COUNT_DEF,
  parameter int CELL_CFG_W = CELL_CFG_W_DEF,
  parameter int CFG_BITS   = CELL_COUNT * CELL_CFG_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                config_en,
  input  logic                bs_in,
  output logic                bs_out,
  output logic [CFG_BITS-1:0] cfg_word,
  output logic                cfg_valid,
  output logic                cfg_load,
  output logic                cfg_err,
  output logic                busy,
  output cfg_state_t          dbg_state
);

  // One extra count value lets an over-length frame park above CFG_BITS
  // instead of wrapping back onto it.
  localparam int CNT_W = $clog2(CFG_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CFG_BITS + 1);

  cfg_state_t          state;
  logic [CFG_BITS-1:0] shadow;
  logic [CNT_W-1:0]    cnt;
  logic                sd_clear;
  logic                sd_enable;
  logic                sd_match;

  assign bs_out    = shadow[CFG_BITS-1];
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  // Sync window control: held at zero outside a hunt, fed while hunting.
  always_comb begin
    sd_clear  = 1'b1;
    sd_enable = 1'b0;
    case (state)
      IDLE: begin
        sd_clear  = !config_en;
        sd_enable = config_en;
      end
      SYNC: begin
        sd_enable = config_en;
        sd_clear  = !config_en || sd_match;
      end
      default: begin
        sd_clear  = 1'b1;
        sd_enable = 1'b0;
      end
    endcase
  end

  fpna_sync_detect u_sync_detect (
    .clk    (clk),
    .reset  (reset),
    .clear  (sd_clear),
    .enable (sd_enable),
    .bit_in (bs_in),
    .match  (sd_match)
  );

  // Frame FSM with payload shift, length count and atomic commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shadow    <= '0;
      cnt       <= '0;
      cfg_word  <= '0;
      cfg_valid <= 1'b0;
      cfg_load  <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      cfg_load <= 1'b0;
      case (state)
        IDLE: begin
          if (config_en) begin
            state <= SYNC;
          end
        end
        SYNC: begin
          if (!config_en) begin
            state   <= IDLE;
            cfg_err <= 1'b1;
          end else if (sd_match) begin
            state <= SHIFT;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          if (config_en) begin
            shadow <= {shadow[CFG_BITS-2:0], bs_in};
            if (cnt != CNT_SAT) begin
              cnt <= cnt + CNT_W'(1);
            end
          end else begin
            if (cnt == CNT_FULL) begin
              cfg_word  <= shadow;
              cfg_load  <= 1'b1;
              cfg_valid <= 1'b1;
              cfg_err   <= 1'b0;
            end else begin
              cfg_err <= 1'b1;
            end
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpna_config_loader.sv
// Self-checking bench for fpna_config_loader: a frame-level reference model
// tracks what each frame must produce, a compare process checks every cycle,
// and directed scenarios pin key values with literal expectations.
module tb_fpna_config_loader;
  import fpna_pkg::*;

  localparam int CFG_BITS = 80;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  logic config_en;
  logic bs_in;
  logic bs_out;
  logic [CFG_BITS-1:0] cfg_word;
  logic cfg_valid, cfg_load, cfg_err, busy;
  cfg_state_t dbg_state;

  always #5 clk = ~clk;

  fpna_config_loader dut (
    .clk       (clk),
    .reset     (reset),
    .config_en (config_en),
    .bs_in     (bs_in),
    .bs_out    (bs_out),
    .cfg_word  (cfg_word),
    .cfg_valid (cfg_valid),
    .cfg_load  (cfg_load),
    .cfg_err   (cfg_err),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_w(input string name, input logic [CFG_BITS-1:0] act,
                         input logic [CFG_BITS-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Frame-level view: collect every enabled sample of the frame, declare sync
  // once the last 8 frame bits read 0xA5, then everything after is payload.
  bit                  m_in_frame;
  bit                  m_synced;
  bit                  frame_q[$];
  bit                  pay_q[$];
  bit                  sh_q[$];   // last CFG_BITS payload bits ever shifted, oldest first
  logic [CFG_BITS-1:0] m_word;
  bit                  m_valid, m_load, m_err;
  logic [7:0]          win;

  function automatic void model_clear();
    m_in_frame = 0;
    m_synced   = 0;
    frame_q    = {};
    pay_q      = {};
    sh_q       = {};
    for (int i = 0; i < CFG_BITS; i++) sh_q.push_back(1'b0);
    m_word  = '0;
    m_valid = 0;
    m_load  = 0;
    m_err   = 0;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_clear();
    end else begin
      m_load = 0;
      if (config_en) begin
        if (!m_in_frame) begin
          m_in_frame = 1;
          m_synced   = 0;
          frame_q    = {};
          pay_q      = {};
        end
        if (m_synced) begin
          pay_q.push_back(bs_in);
          sh_q.push_back(bs_in);
          void'(sh_q.pop_front());
        end else begin
          frame_q.push_back(bs_in);
          if (frame_q.size() >= 8) begin
            for (int k = 0; k < 8; k++) win[7-k] = frame_q[frame_q.size()-8+k];
            if (win == 8'hA5) m_synced = 1;
          end
        end
      end else if (m_in_frame) begin
        m_in_frame = 0;
        if (m_synced && pay_q.size() == CFG_BITS) begin
          for (int i = 0; i < CFG_BITS; i++) m_word[CFG_BITS-1-i] = pay_q[i];
          m_load  = 1;
          m_valid = 1;
          m_err   = 0;
        end else begin
          m_err = 1;
        end
      end
    end
  end

  // ---------------- scoreboard / compare process ----------------
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      check_w("cfg_word", cfg_word, m_word);
      check1("cfg_valid", cfg_valid, m_valid);
      check1("cfg_load", cfg_load, m_load);
      check1("cfg_err", cfg_err, m_err);
      check1("busy", busy, m_in_frame);
      check1("bs_out", bs_out, sh_q[0]);
    end
  end

  // ---------------- driver tasks ----------------
  logic [CFG_BITS-1:0] cap;  // bs_out seen before each payload bit of the latest frame

  task automatic drive(input logic en, input logic b);
    @(negedge clk);
    config_en = en;
    bs_in     = b;
  endtask

  function automatic logic [255:0] rand_vec();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // junk bits, sync word, pay_len payload bits (MSB first), one low sample, gap idles
  task automatic send_frame(input logic [31:0] junk, input int junk_len,
                            input logic [255:0] pay, input int pay_len, input int gap);
    logic [7:0] sw;
    sw = SYNC_WORD;
    for (int i = junk_len - 1; i >= 0; i--) drive(1'b1, junk[i]);
    for (int i = 7; i >= 0; i--) drive(1'b1, sw[i]);
    for (int j = 0; j < pay_len; j++) begin
      @(negedge clk);
      if (j < CFG_BITS) cap[CFG_BITS-1-j] = bs_out;
      config_en = 1'b1;
      bs_in     = pay[pay_len-1-j];
    end
    drive(1'b0, 1'($urandom_range(0, 1)));
    repeat (gap) drive(1'b0, 1'($urandom_range(0, 1)));
  endtask

  // ---------------- directed + random stimulus ----------------
  localparam logic [CFG_BITS-1:0] P0 = 80'h0123456789ABCDEF0011;
  logic [CFG_BITS-1:0] va, vb, vc, vd;

  initial begin
    reset     = 1'b1;
    config_en = 1'b0;
    bs_in     = 1'b0;
    repeat (2) @(negedge clk);
    check_w("rst_word", cfg_word, '0);
    check1("rst_valid", cfg_valid, 1'b0);
    check1("rst_load", cfg_load, 1'b0);
    check1("rst_err", cfg_err, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_bs_out", bs_out, 1'b0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // good frame with the known payload
    send_frame(32'h0, 0, 256'(P0), CFG_BITS, 0);
    @(negedge clk);
    check_w("good_word", cfg_word, P0);
    check1("good_load", cfg_load, 1'b1);
    check1("good_valid", cfg_valid, 1'b1);
    check1("good_err", cfg_err, 1'b0);
    @(negedge clk);
    check1("good_load_drop", cfg_load, 1'b0);

    // short, long and very long (counter saturation) frames
    send_frame(32'h0, 0, rand_vec(), CFG_BITS - 1, 0);
    @(negedge clk);
    check1("short_err", cfg_err, 1'b1);
    check_w("short_word", cfg_word, P0);
    check1("short_load", cfg_load, 1'b0);
    send_frame(32'h0, 0, P0, CFG_BITS, 1);
    send_frame(32'h0, 0, rand_vec(), CFG_BITS + 1, 0);
    @(negedge clk);
    check1("long_err", cfg_err, 1'b1);
    check_w("long_word", cfg_word, P0);
    send_frame(32'h0, 0, rand_vec(), 208, 0);
    @(negedge clk);
    check1("sat_err", cfg_err, 1'b1);
    check1("sat_load", cfg_load, 1'b0);

    // daisy chain: A then B back-to-back, bs_out replays A during B
    va = CFG_BITS'(rand_vec());
    vb = CFG_BITS'(rand_vec());
    send_frame(32'h0, 0, 256'(va), CFG_BITS, 0);
    send_frame(32'h0, 0, 256'(vb), CFG_BITS, 0);
    @(negedge clk);
    check_w("daisy_bs_out", cap, va);
    check_w("daisy_word", cfg_word, vb);
    check1("daisy_load", cfg_load, 1'b1);

    // sync hunt through junk
    vc = CFG_BITS'(rand_vec());
    send_frame(32'h5AFF, 16, 256'(vc), CFG_BITS, 0);
    @(negedge clk);
    check_w("hunt_word", cfg_word, vc);
    check1("hunt_err", cfg_err, 1'b0);

    // frame dropped during junk
    for (int i = 7; i >= 0; i--) drive(1'b1, (8'h5A >> i) & 8'h1 ? 1'b1 : 1'b0);
    drive(1'b0, 1'b0);
    @(negedge clk);
    check1("drop_err", cfg_err, 1'b1);
    check1("drop_busy", busy, 1'b0);
    check_w("drop_state", 80'(dbg_state), 80'(IDLE));
    check_w("drop_word", cfg_word, vc);

    // randomized frames
    for (int n = 0; n < 25; n++) begin
      int jl, pl, sel;
      jl  = $urandom_range(0, 12);
      sel = $urandom_range(0, 5);
      pl  = (sel == 0) ? CFG_BITS - 1 : (sel == 1) ? CFG_BITS + 1 : CFG_BITS;
      send_frame($urandom, jl, rand_vec(), pl, $urandom_range(0, 2));
    end

    // reset after 40 payload bits
    begin
      logic [7:0] sw;
      sw = SYNC_WORD;
      for (int i = 7; i >= 0; i--) drive(1'b1, sw[i]);
      for (int j = 0; j < 40; j++) drive(1'b1, 1'($urandom_range(0, 1)));
    end
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check_w("midrst_word", cfg_word, '0);
    check1("midrst_valid", cfg_valid, 1'b0);
    check1("midrst_load", cfg_load, 1'b0);
    check1("midrst_err", cfg_err, 1'b0);
    check1("midrst_busy", busy, 1'b0);
    check1("midrst_bs_out", bs_out, 1'b0);
    check_w("midrst_state", 80'(dbg_state), 80'(IDLE));
    @(negedge clk);
    config_en = 1'b0;
    bs_in     = 1'b0;
    reset     = 1'b0;
    repeat (2) @(negedge clk);

    vd = CFG_BITS'(rand_vec());
    send_frame(32'h0, 0, 256'(vd), CFG_BITS, 0);
    @(negedge clk);
    check_w("after_rst_word", cfg_word, vd);
    check1("after_rst_valid", cfg_valid, 1'b1);
    check1("after_rst_load", cfg_load, 1'b1);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fpna_config_loader.md
# fpna_config_loader

Serial configuration loader for the FPNA neurochip; sits directly upstream of the neuron array. It frames the external bitstream (`bs_in`, qualified by `config_en`) with a sync word and shifts the payload into a shadow register. It commits the complete configuration word atomically to the array only when the frame length is exact. It also drives `bs_out` so several chips can be daisy-chained.

## Interface
- `CELL_COUNT`, default 10: number of neuron cells configured.
- `CELL_CFG_W`, default 8: configuration bits per cell.
- `CFG_BITS`, default `CELL_COUNT*CELL_CFG_W` (80): payload length per frame.
- `clk` (in, 1): single clock; all state changes on its rising edge.
- `reset` (in, 1): asynchronous, active-high; clears all state.
- `config_en` (in, 1): frame enable; high for sync plus payload, low otherwise.
- `bs_in` (in, 1): serial bitstream, MSB first, sampled every clk while `config_en` is high.
- `bs_out` (out, 1): bit shifted out of the shadow register (daisy-chain output).
- `cfg_word` (out, `CFG_BITS`): committed configuration. Cell i uses `cfg_word[i*CELL_CFG_W +: CELL_CFG_W]`.
- `cfg_valid` (out, 1): set by the first successful commit; cleared only by reset.
- `cfg_load` (out, 1): one-cycle pulse in the cycle `cfg_word` updates.
- `cfg_err` (out, 1): last frame failed; cleared by the next good commit or by reset.
- `busy` (out, 1): state is not IDLE.

## Operation
- FSM states:
  - IDLE
  - SYNC: hunting for the sync word `0xA5`
  - SHIFT: loading payload
- IDLE:
  - `sync_reg` is held at 0.
  - `config_en`=1 → `sync_reg <= {7'b0, bs_in}`, go to SYNC. The first sampled bit counts as sync bit 7.
- SYNC:
  - `nxt = {sync_reg[6:0], bs_in}`.
  - If `nxt == 0xA5`: go to SHIFT and set `cnt <= 0`.
  - Otherwise `sync_reg <= nxt` and stay.
  - `config_en`=0 → IDLE, `cfg_err <= 1`, no commit.
- SHIFT, `config_en`=1:
  - `shadow <= {shadow[CFG_BITS-2:0], bs_in}`.
  - `cnt` increments, saturating at `CFG_BITS+1`.
- SHIFT, `config_en`=0 (end of frame):
  - If `cnt == CFG_BITS`: `cfg_word <= shadow`, `cfg_load <= 1`, `cfg_valid <= 1`, `cfg_err <= 0`.
  - Otherwise `cfg_err <= 1`; `cfg_word` and `cfg_valid` are unchanged.
  - Both cases → IDLE.
- The first payload bit ends up in `cfg_word[CFG_BITS-1]`, i.e. the MSB of cell `CELL_COUNT-1`.
- `bs_out = shadow[CFG_BITS-1]`, combinational from the register. The shadow register is not cleared between frames, so frame n pushes out frame n-1's payload MSB first.
- `cnt` width is `$clog2(CFG_BITS+2)`. An over-length frame saturates `cnt` and cannot wrap back to `CFG_BITS`.
- `cfg_word` never changes during SYNC or SHIFT, so the array keeps running on the old configuration.

## Timing
- Reset values:
  - `cfg_word`=0, `cfg_valid`=0, `cfg_load`=0, `cfg_err`=0, `busy`=0, `bs_out`=0.
  - Shadow, `sync_reg` and `cnt` = 0; state = IDLE.
- Frame length: `config_en` must be high for exactly 8+`CFG_BITS` consecutive samples.
- Commit latency: if `config_en` is first sampled low at edge k, `cfg_word`/`cfg_load` are valid after edge k. `cfg_load` drops after edge k+1.
- Back-to-back frames:
  - `config_en` low for one sample (the commit edge) then high again is legal.
  - That high sample is taken in IDLE as sync bit 7.
- Early sync candidates: the sync word cannot match before 8 bits (MSB of `0xA5` is 1, and `sync_reg` is zero-filled).
- Reset mid-frame:
  - Immediate return to IDLE.
  - The partial frame is discarded and `cfg_word` returns to 0.
  - No `cfg_load` pulse.
- `busy` follows the registered state: high from the edge after the first `config_en`=1 sample through the end-of-frame edge.

## Structure
- `fpna_pkg` holds:
  - `SYNC_WORD` (8'hA5)
  - default `CELL_COUNT` and `CELL_CFG_W`
  - state enum `cfg_state_t` {IDLE, SYNC, SHIFT}
- The neuron array imports the same package for its cell slicing.
- One sub-module, `fpna_sync_detect`: an 8-bit shift register plus comparator, with clear and enable inputs and a match output. Everything else stays flat in `fpna_config_loader`.

## Test plan
- Reset: assert `reset` mid-cycle → all outputs 0 immediately, `busy`=0.
- Good frame: sync `0xA5`, then 80 bits of payload `0x0123456789ABCDEF0011`, then `config_en` low → one `cfg_load` pulse, `cfg_word`=`0x0123456789ABCDEF0011`, `cfg_valid`=1, `cfg_err`=0.
- Short frame (79 bits) and long frame (81 bits), each after a good frame → `cfg_err`=1, `cfg_word` unchanged, no `cfg_load`.
- Sync hunt:
  - Junk `0x5A 0xFF`, then `0xA5` plus 80 bits → commits correctly.
  - `config_en` dropped during the junk → `cfg_err`=1, state IDLE.
- Daisy chain: good frame A, then good frame B back-to-back → during B's payload, `bs_out` reproduces A's 80 bits MSB first, one bit per clk, and B commits.
- Reset after 40 payload bits → IDLE, `cfg_word`=0, `cfg_valid`=0. A following good frame commits normally.
